// File: rtl/s_frame_checksum_if.sv
// Word-stream bundle between the pipe's receive/transmit ports and the checksum stage.
// The slave modport is the stage's view; master is the pipe/host side.
interface s_frame_checksum_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx;

    modport slave (
        input  rx_valid,
        input  rx,
        output rx_ready,
        output tx_valid,
        output tx,
        input  tx_ready
    );

    modport master (
        output rx_valid,
        output rx,
        input  rx_ready,
        input  tx_valid,
        input  tx,
        output tx_ready
    );
endinterface

// File: rtl/s_frame_checksum.sv
// Forwards length-prefixed frames unchanged and appends a payload checksum word
// after each frame, behind a single-entry ready/valid output register.
module s_frame_checksum #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter bit CHECK_INV  = 1'b0
) (
    input  logic                 s_clk,
    input  logic                 s_rst_n,
    s_frame_checksum_if.slave    st,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count
);

    typedef enum logic [1:0] {
        S_HEAD = 2'd0,
        S_BODY = 2'd1,
        S_SUM  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] tx_p0, tx_nxt;
    logic                  vld_p0, vld_nxt;
    logic [DATA_WIDTH-1:0] remain, remain_nxt;
    logic [DATA_WIDTH-1:0] sum, sum_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  free;
    logic                  rx_ready;
    logic                  accept;

    function automatic logic [DATA_WIDTH-1:0] wrap_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] finalize_sum(
        input logic [DATA_WIDTH-1:0] s
    );
        return CHECK_INV ? ~s : s;
    endfunction

    // Output register can take a new word when empty or being drained this cycle.
    assign free     = ~vld_p0 | st.tx_ready;
    assign rx_ready = free & (state != S_SUM) & s_rst_n;
    assign accept   = st.rx_valid & rx_ready;

    assign st.rx_ready = rx_ready;
    assign st.tx_valid = vld_p0;
    assign st.tx       = tx_p0;
    assign busy        = (state != S_HEAD);

    always_comb begin
        state_nxt  = state;
        tx_nxt     = tx_p0;
        vld_nxt    = free ? 1'b0 : vld_p0;
        remain_nxt = remain;
        sum_nxt    = sum;
        cnt_nxt    = frame_count;
        case (state)
            S_HEAD: begin
                if (accept) begin
                    tx_nxt     = st.rx;
                    vld_nxt    = 1'b1;
                    remain_nxt = st.rx;
                    sum_nxt    = '0;
                    state_nxt  = (st.rx == '0) ? S_SUM : S_BODY;
                end
            end
            S_BODY: begin
                if (accept) begin
                    tx_nxt     = st.rx;
                    vld_nxt    = 1'b1;
                    sum_nxt    = wrap_add(sum, st.rx);
                    remain_nxt = remain - DATA_WIDTH'(1);
                    if (remain == DATA_WIDTH'(1)) begin
                        state_nxt = S_SUM;
                    end
                end
            end
            S_SUM: begin
                // Checksum slot: input is stalled, so this costs one bubble per frame.
                if (free) begin
                    tx_nxt    = finalize_sum(sum);
                    vld_nxt   = 1'b1;
                    cnt_nxt   = frame_count + CNT_WIDTH'(1);
                    state_nxt = S_HEAD;
                end
            end
            default: begin
                state_nxt = S_HEAD;
            end
        endcase
    end

    // Stage p0: output register plus frame bookkeeping.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= S_HEAD;
            tx_p0       <= '0;
            vld_p0      <= 1'b0;
            remain      <= '0;
            sum         <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            tx_p0       <= tx_nxt;
            vld_p0      <= vld_nxt;
            remain      <= remain_nxt;
            sum         <= sum_nxt;
            frame_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_s_frame_checksum.sv
// Directed and soak bench for s_frame_checksum with a normal and an inverted-checksum instance.
module tb_s_frame_checksum;

    logic        s_clk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        busy, busy_i;
    logic [15:0] frame_count, frame_count_i;

    s_frame_checksum_if #(.DATA_WIDTH(16)) bus ();
    s_frame_checksum_if #(.DATA_WIDTH(16)) bus_i ();

    s_frame_checksum #(.DATA_WIDTH(16), .CNT_WIDTH(16), .CHECK_INV(1'b0)) dut (
        .s_clk       (s_clk),
        .s_rst_n     (s_rst_n),
        .st          (bus.slave),
        .busy        (busy),
        .frame_count (frame_count)
    );

    s_frame_checksum #(.DATA_WIDTH(16), .CNT_WIDTH(16), .CHECK_INV(1'b1)) dut_inv (
        .s_clk       (s_clk),
        .s_rst_n     (s_rst_n),
        .st          (bus_i.slave),
        .busy        (busy_i),
        .frame_count (frame_count_i)
    );

    always #5 s_clk = ~s_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bubbles = 0;
    logic [15:0] out_q[$];
    int          cyc_q[$];

    always @(posedge s_clk) cyc <= cyc + 1;

    // A word seen valid and ready at the falling edge transfers on the next rising edge.
    always @(negedge s_clk) begin
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            out_q.push_back(bus.tx);
            cyc_q.push_back(cyc);
        end
    end

    task automatic clear_out();
        out_q.delete();
        cyc_q.delete();
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx = d;
        @(negedge s_clk);
        while (bus.rx_ready !== 1'b1 && n < 200) begin
            @(negedge s_clk);
            n++;
        end
        bubbles += n;
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted, rx_ready=%b required 1", d, bus.rx_ready);
        end
        @(posedge s_clk);
        #1;
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (out_q.size() < n && k < 200) begin
            @(posedge s_clk);
            #1;
            k++;
        end
        checks++;
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL wait_out: got %0d words, required %0d", out_q.size(), n);
        end
    endtask

    task automatic check_seq(input string name, input logic [15:0] exp[]);
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= out_q.size()) begin
                errors++;
                $display("FAIL %s[%0d]: missing word, required %h", name, i, exp[i]);
            end else if (out_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got %h required %h", name, i, out_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", bus.tx_valid); end
        checks++; if (bus.tx !== 16'h0000) begin errors++; $display("FAIL reset_tx: got %h required 0000", bus.tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d required 0", frame_count); end
        checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b required 0", bus.rx_ready); end
        repeat (2) @(posedge s_clk);
        #1;
        s_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] exp[] = '{16'h0003, 16'h0001, 16'h0002, 16'hFFFF, 16'h0002};
        clear_out();
        send(16'h0003); send(16'h0001); send(16'h0002); send(16'hFFFF);
        bus.rx_valid = 1'b0;
        wait_out(5);
        check_seq("basic", exp);
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count: got %0d required 1", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b required 0", busy); end
    endtask

    task automatic test_zero_len();
        logic [15:0] exp[] = '{16'h0000, 16'h0000};
        clear_out();
        send(16'h0000);
        bus.rx_valid = 1'b0;
        wait_out(2);
        check_seq("zero", exp);
        checks++;
        if (cyc_q.size() >= 2 && cyc_q[1] - cyc_q[0] !== 1) begin
            errors++; $display("FAIL zero_consecutive: gap %0d required 1", cyc_q[1] - cyc_q[0]);
        end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL zero_frame_count: got %0d required 2", frame_count); end
        // Inverted instance, stepped by hand.
        bus_i.rx_valid = 1'b1;
        bus_i.rx = 16'h0000;
        @(negedge s_clk);
        checks++; if (bus_i.rx_ready !== 1'b1) begin errors++; $display("FAIL inv_rx_ready: got %b required 1", bus_i.rx_ready); end
        @(posedge s_clk); #1;
        bus_i.rx_valid = 1'b0;
        @(negedge s_clk);
        checks++; if (bus_i.tx_valid !== 1'b1 || bus_i.tx !== 16'h0000) begin errors++; $display("FAIL inv_head: got v=%b %h required v=1 0000", bus_i.tx_valid, bus_i.tx); end
        @(negedge s_clk);
        checks++; if (bus_i.tx_valid !== 1'b1 || bus_i.tx !== 16'hFFFF) begin errors++; $display("FAIL inv_sum: got v=%b %h required v=1 ffff", bus_i.tx_valid, bus_i.tx); end
        @(negedge s_clk);
        checks++; if (bus_i.tx_valid !== 1'b0) begin errors++; $display("FAIL inv_drain: got v=%b required 0", bus_i.tx_valid); end
        checks++; if (frame_count_i !== 16'd1) begin errors++; $display("FAIL inv_frame_count: got %0d required 1", frame_count_i); end
        @(posedge s_clk); #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp[] = '{16'h0002, 16'h1234, 16'h1111, 16'h2345};
        clear_out();
        send(16'h0002);
        send(16'h1234);
        bus.tx_ready = 1'b0;
        bus.rx = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge s_clk);
            checks++; if (bus.tx !== 16'h1234) begin errors++; $display("FAIL bp_tx[%0d]: got %h required 1234", i, bus.tx); end
            checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL bp_tx_valid[%0d]: got %b required 1", i, bus.tx_valid); end
            checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL bp_rx_ready[%0d]: got %b required 0", i, bus.rx_ready); end
            @(posedge s_clk); #1;
        end
        bus.tx_ready = 1'b1;
        send(16'h1111);
        bus.rx_valid = 1'b0;
        wait_out(4);
        check_seq("bp", exp);
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL bp_frame_count: got %0d required 3", frame_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp[] = '{16'h0001, 16'hAAAA, 16'hAAAA, 16'h0002, 16'h0001, 16'h0001, 16'h0002};
        clear_out();
        bubbles = 0;
        send(16'h0001); send(16'hAAAA);
        send(16'h0002); send(16'h0001); send(16'h0001);
        bus.rx_valid = 1'b0;
        checks++; if (bubbles !== 1) begin errors++; $display("FAIL b2b_bubbles: got %0d required 1", bubbles); end
        @(negedge s_clk);
        checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL b2b_sum_bubble: got %b required 0", bus.rx_ready); end
        @(negedge s_clk);
        checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_sum: got %b required 1", bus.rx_ready); end
        @(posedge s_clk); #1;
        wait_out(7);
        check_seq("b2b", exp);
        checks++;
        if (cyc_q.size() >= 7 && cyc_q[6] - cyc_q[0] !== 6) begin
            errors++; $display("FAIL b2b_span: got %0d cycles required 6", cyc_q[6] - cyc_q[0]);
        end
        checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL b2b_frame_count: got %0d required 5", frame_count); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp[] = '{16'h0001, 16'h0005, 16'h0005};
        send(16'h0004); send(16'h0010); send(16'h0020);
        bus.rx_valid = 1'b0;
        s_rst_n = 1'b0;
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_valid: got %b required 0", bus.tx_valid); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_mid_frame_count: got %0d required 0", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
        repeat (2) @(posedge s_clk);
        #1;
        s_rst_n = 1'b1;
        clear_out();
        send(16'h0001); send(16'h0005);
        bus.rx_valid = 1'b0;
        wait_out(3);
        check_seq("rst_mid", exp);
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL rst_mid_frame_count_after: got %0d required 1", frame_count); end
    endtask

    task automatic test_soak();
        logic [15:0] in_q[$];
        logic [15:0] exp_q[$];
        logic [15:0] s, w;
        int nlen, idx, cycles, bad;
        logic acc;
        clear_out();
        for (int f = 0; f < 1000; f++) begin
            nlen = $urandom_range(0, 20);
            in_q.push_back(16'(nlen));
            exp_q.push_back(16'(nlen));
            s = 16'h0000;
            for (int j = 0; j < nlen; j++) begin
                w = 16'($urandom);
                in_q.push_back(w);
                exp_q.push_back(w);
                s = s + w;
            end
            exp_q.push_back(s);
        end
        idx = 0;
        cycles = 0;
        bus.rx_valid = 1'b0;
        while ((idx < in_q.size() || out_q.size() < exp_q.size()) && cycles < 80000) begin
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            if (idx < in_q.size()) begin
                if (!bus.rx_valid) bus.rx_valid = ($urandom_range(0, 2) != 0);
                bus.rx = in_q[idx];
            end else begin
                bus.rx_valid = 1'b0;
            end
            @(negedge s_clk);
            acc = bus.rx_valid && bus.rx_ready;
            @(posedge s_clk); #1;
            if (acc) begin
                idx++;
                bus.rx_valid = ($urandom_range(0, 2) != 0);
            end
            cycles++;
        end
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        checks++;
        if (cycles >= 80000) begin
            errors++; $display("FAIL soak_timeout: sent %0d/%0d, got %0d/%0d words", idx, in_q.size(), out_q.size(), exp_q.size());
        end
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL soak_count: got %0d words required %0d", out_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                errors++;
                if (bad < 10) $display("FAIL soak_word[%0d]: got %h required %h", i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
                bad++;
            end
        end
        checks++; if (frame_count !== 16'd1001) begin errors++; $display("FAIL soak_frame_count: got %0d required 1001", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL soak_busy: got %b required 0", busy); end
    endtask

    initial begin
        bus.rx_valid   = 1'b0;
        bus.rx         = 16'h0000;
        bus.tx_ready   = 1'b1;
        bus_i.rx_valid = 1'b0;
        bus_i.rx       = 16'h0000;
        bus_i.tx_ready = 1'b1;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_frame_checksum.md
# s_frame_checksum

System-side stream stage that sits between the Opal Kelly pipe's receive port (`sys_rx*`) and its transmit port (`sys_tx*`), in the place currently occupied by the direct loopback. It parses length-prefixed frames of words received from the host and forwards each frame unchanged. After the last payload word of each frame it appends one checksum word, so host software can verify the round trip. It runs entirely in the system clock domain and uses the pipe's ready/valid handshake on both sides.

## Interface
- `DATA_WIDTH`, default 16: word width; also the width of the length field and of the checksum.
- `CNT_WIDTH`, default 16: width of `frame_count`.
- `CHECK_INV`, default 0: 1 = the appended checksum is the bitwise inverse of the sum.

One clock; reset is asynchronous and active-low.
- `s_clk`  in  1: system clock.
- `s_rst_n`  in  1: asynchronous reset, active-low.
- `rx_valid`  in  1: upstream word valid (from the pipe's `sys_rx_valid`).
- `rx_ready`  out  1: this block accepts the word (to the pipe's `sys_rx_ready`).
- `rx`  in  DATA_WIDTH: upstream word.
- `tx_valid`  out  1: downstream word valid (to the pipe's `sys_tx_valid`).
- `tx_ready`  in  1: downstream accepts the word (from the pipe's `sys_tx_ready`).
- `tx`  out  DATA_WIDTH: downstream word.
- `busy`  out  1: high while a frame is in progress, i.e. the state is not S_HEAD.
- `frame_count`  out  CNT_WIDTH: number of checksum words emitted, modulo 2^CNT_WIDTH.

## Operation
- **Frame format in:** header word H = payload length N, followed by N payload words. N = 0 is legal.
- **Frame format out:** H, then the N payload words, then C. C = (sum of payload words mod 2^DATA_WIDTH), inverted if CHECK_INV = 1. The header word is not included in the sum.
- **Output register:** single-entry register holding `tx` and `tx_valid`. The register is free when `~tx_valid | tx_ready`.
- **Input accept:** `accept = rx_valid & rx_ready`. `rx_ready = free & (state != S_SUM)`. `rx_ready` is 0 while `s_rst_n` is low.
- **Internal registers:** `remain` (DATA_WIDTH bits) and `sum` (DATA_WIDTH bits).
- **State S_HEAD** (reset state):
  - On accept: `tx <= rx`, `tx_valid <= 1`, `remain <= rx`, `sum <= 0`.
  - Go to S_SUM if `rx == 0`, else go to S_BODY.
- **State S_BODY:**
  - On accept: `tx <= rx`, `tx_valid <= 1`, `sum <= sum + rx` (wraps), `remain <= remain - 1`.
  - Go to S_SUM when the accepted word had `remain == 1`.
- **State S_SUM:**
  - No input is accepted.
  - When the output register is free: `tx <= CHECK_INV ? ~sum : sum`, `tx_valid <= 1`, `frame_count <= frame_count + 1` (wraps), go to S_HEAD.
- **Output register drain:** if the register is free and nothing new is loaded, `tx_valid <= 0`. `tx` holds its last value.
- **Reset values:** state = S_HEAD, `tx_valid` = 0, `tx` = 0, `busy` = 0, `frame_count` = 0, `sum` = 0, `remain` = 0.
- **Reset mid-frame:** the partial frame is discarded with no checksum emitted. `tx_valid` drops to 0 immediately (asynchronously). After release, the next accepted word is treated as a header.

## Timing
- **Latency:** a word accepted at rising edge k is presented on `tx` with `tx_valid` = 1 after edge k.
- **Checksum timing:** C appears one edge after the last payload word is loaded into the output register, provided `tx_ready` = 1.
- **Throughput:** one word per cycle during header and payload. Exactly one input bubble per frame (the S_SUM cycle). A frame of N payload words occupies N+2 output cycles.
- **Backpressure:** while `tx_valid & ~tx_ready`, `tx` and `tx_valid` hold stable and `rx_ready` = 0. No word is dropped or duplicated.
- **Handshake rules:**
  - `tx_valid`, once asserted, is never deasserted before a transfer completes.
  - `rx_ready` may depend combinationally on `tx_ready`.
- **Simultaneous drain and load:** when `tx_valid & tx_ready` coincides with an accept (or with the S_SUM load), the new word replaces the old one in the same cycle.

## Test plan
- **Basic frame:** input 0x0003, 0x0001, 0x0002, 0xFFFF with `tx_ready` = 1 → output 0x0003, 0x0001, 0x0002, 0xFFFF, 0x0002; `frame_count` = 1; `busy` low afterwards.
- **Zero length:** input 0x0000 → output 0x0000, 0x0000 on consecutive cycles; `frame_count` increments by 1. Repeat with CHECK_INV = 1 → output 0x0000, 0xFFFF.
- **Backpressure:** frame 0x0002, 0x1234, 0x1111 with `tx_ready` held low for 5 cycles while `tx` = 0x1234 → `tx` stays 0x1234 and `rx_ready` stays 0 throughout; the final output sequence is 0x0002, 0x1234, 0x1111, 0x2345.
- **Back-to-back frames:** `rx_valid` held high and `tx_ready` = 1, sending frames [1, 0xAAAA] and [2, 0x0001, 0x0001] → output 0x0001, 0xAAAA, 0xAAAA, 0x0002, 0x0001, 0x0001, 0x0002; exactly one `rx_ready` = 0 cycle per frame.
- **Reset mid-frame:** header 0x0004, two payload words, then pulse `s_rst_n` low → `tx_valid` = 0 immediately and `frame_count` = 0. Then send frame [1, 0x0005] → output 0x0001, 0x0005, 0x0005.
- **Random soak:** 1000 random frames (N in 0..20) with random `tx_ready` and `rx_valid` → the scoreboard matches every word and checksum, and `frame_count` = 1000 mod 2^CNT_WIDTH.
